// File: rtl/abus_master.sv
// A-bus initiator: turns one CPU-side request (16 or 32 bit) into one or two
// 16-bit A-bus cycles with per-region wait states, AWAIT_N stretching and a
// timeout abort. Every step except DONE->IDLE advances only on CE_R ticks.
module abus_master #(
  parameter int TIMEOUT_TICKS = 1023
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        REQ,
  input  logic [26:0] ADDR,
  input  logic [31:0] DI,
  input  logic [3:0]  WE,
  input  logic        SIZE,
  output logic [31:0] DO,
  output logic        ACK,
  output logic        BUSY,
  output logic        ERR,
  input  logic [3:0]  CS0_WAIT,
  input  logic [3:0]  CS1_WAIT,
  input  logic [3:0]  CS2_WAIT,
  output logic [25:0] AA,
  output logic [15:0] ADO,
  input  logic [15:0] ADI,
  output logic        ACS0_N,
  output logic        ACS1_N,
  output logic        ACS2_N,
  output logic        ARD_N,
  output logic        AWRL_N,
  output logic        AWRU_N,
  input  logic        AWAIT_N
);
  // timeout counter only has to reach TIMEOUT_TICKS-1 before the abort tick
  localparam int TW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

  state_t        state;
  logic [26:1]   addr_q;
  logic [31:0]   di_q;
  logic [3:0]    we_q;
  logic          size_q, hsel, dummy_q, err_q;
  logic [3:0]    wcnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   rd_q;

  logic [26:1] s_addr;
  logic [31:0] s_di;
  logic        s_size, s_hsel, s_lo;
  logic [2:0]  s_cs;
  logic [3:0]  s_wait;
  logic [25:0] s_aa;
  logic [15:0] s_ado;
  logic        cur_lo, cur_wr, last_half;
  logic [1:0]  cur_we;
  logic        unused;

  assign unused = ADDR[0];

  // Setup values for the next half: from the live request in IDLE (first half),
  // from the latched request afterwards (the second half is always the odd one).
  always_comb begin
    s_addr = ADDR[26:1];
    s_di   = DI;
    s_size = SIZE;
    s_hsel = SIZE & (|WE) & (WE[3:2] == 2'b00);
    if (state != IDLE) begin
      s_addr = addr_q;
      s_di   = di_q;
      s_size = size_q;
      s_hsel = 1'b1;
    end
    s_lo    = s_hsel | ~s_size;
    s_aa    = s_size ? {s_addr[25:2], s_hsel, 1'b0} : {s_addr[25:1], 1'b0};
    s_ado   = s_lo ? s_di[15:0] : s_di[31:16];
    s_cs[0] = (s_addr[26:25] == 2'b01);
    s_cs[1] = (s_addr[26:24] == 3'b100);
    s_cs[2] = (s_addr[26:20] == 7'h58);
    s_wait  = s_cs[0] ? CS0_WAIT : (s_cs[1] ? CS1_WAIT : CS2_WAIT);
  end

  // 16-bit accesses and the odd half of 32-bit accesses use the low data lane
  assign cur_lo    = hsel | ~size_q;
  assign cur_we    = cur_lo ? we_q[1:0] : we_q[3:2];
  assign cur_wr    = |we_q;
  assign last_half = ~size_q | hsel | (cur_wr & (we_q[1:0] == 2'b00));

  // Bus sequencer with registered bus and handshake outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      ACS0_N <= 1'b1; ACS1_N <= 1'b1; ACS2_N <= 1'b1;
      ARD_N  <= 1'b1; AWRL_N <= 1'b1; AWRU_N <= 1'b1;
      AA <= '0; ADO <= '0; DO <= '0;
      ACK <= 1'b0; BUSY <= 1'b0; ERR <= 1'b0;
      addr_q <= '0; di_q <= '0; we_q <= '0; size_q <= 1'b0;
      hsel <= 1'b0; dummy_q <= 1'b0; err_q <= 1'b0;
      wcnt <= '0; tcnt <= '0; rd_q <= '0;
    end else begin
      case (state)
        IDLE: if (CE_R && REQ) begin
          addr_q  <= ADDR[26:1];
          di_q    <= DI;
          we_q    <= WE;
          size_q  <= SIZE;
          hsel    <= s_hsel;
          err_q   <= 1'b0;
          BUSY    <= 1'b1;
          dummy_q <= ~(|s_cs);
          if (!(|s_cs)) begin
            // unmapped: no bus cycle, reads float high
            rd_q  <= (|WE) ? 32'h0 : 32'hFFFF_FFFF;
            state <= RECOVER;
          end else begin
            rd_q   <= '0;
            AA     <= s_aa;
            ADO    <= s_ado;
            ACS0_N <= ~s_cs[0]; ACS1_N <= ~s_cs[1]; ACS2_N <= ~s_cs[2];
            wcnt   <= s_wait;
            tcnt   <= '0;
            state  <= SETUP;
          end
        end
        SETUP: if (CE_R) begin
          ARD_N  <= cur_wr;
          AWRU_N <= ~(cur_wr & cur_we[1]);
          AWRL_N <= ~(cur_wr & cur_we[0]);
          state  <= STROBE;
        end
        STROBE: if (CE_R) begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else if (AWAIT_N || tcnt == TW'(TIMEOUT_TICKS - 1)) begin
            // normal completion or timeout: the aborted half reads as FFFF
            if (!cur_wr) begin
              if (cur_lo) rd_q[15:0]  <= AWAIT_N ? ADI : 16'hFFFF;
              else        rd_q[31:16] <= AWAIT_N ? ADI : 16'hFFFF;
            end
            if (!AWAIT_N) err_q <= 1'b1;
            ARD_N  <= 1'b1; AWRL_N <= 1'b1; AWRU_N <= 1'b1;
            ACS0_N <= 1'b1; ACS1_N <= 1'b1; ACS2_N <= 1'b1;
            state  <= RECOVER;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RECOVER: if (CE_R) begin
          if (!dummy_q && !last_half && !err_q) begin
            hsel   <= 1'b1;
            AA     <= s_aa;
            ADO    <= s_ado;
            ACS0_N <= ~s_cs[0]; ACS1_N <= ~s_cs[1]; ACS2_N <= ~s_cs[2];
            wcnt   <= s_wait;
            tcnt   <= '0;
            state  <= SETUP;
          end else begin
            ACK   <= 1'b1;
            ERR   <= err_q;
            DO    <= rd_q;
            state <= DONE;
          end
        end
        DONE: begin
          ACK   <= 1'b0;
          ERR   <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_abus_master.sv
// Scoreboard bench for abus_master: each scenario pushes its expected result
// and bus cycles, a negedge monitor records what the bus actually did.
module tb_abus_master;
  logic        CLK, RST_N, REQ, SIZE;
  logic        CE_R = 1'b0;
  logic        AWAIT_N = 1'b1;
  logic [15:0] ADI = 16'h0;
  logic [26:0] ADDR;
  logic [31:0] DI, DO;
  logic [3:0]  WE, CS0_WAIT, CS1_WAIT, CS2_WAIT;
  logic        ACK, BUSY, ERR;
  logic [25:0] AA;
  logic [15:0] ADO;
  logic        ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N;

  abus_master #(.TIMEOUT_TICKS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .REQ(REQ), .ADDR(ADDR), .DI(DI),
    .WE(WE), .SIZE(SIZE), .DO(DO), .ACK(ACK), .BUSY(BUSY), .ERR(ERR),
    .CS0_WAIT(CS0_WAIT), .CS1_WAIT(CS1_WAIT), .CS2_WAIT(CS2_WAIT),
    .AA(AA), .ADO(ADO), .ADI(ADI), .ACS0_N(ACS0_N), .ACS1_N(ACS1_N),
    .ACS2_N(ACS2_N), .ARD_N(ARD_N), .AWRL_N(AWRL_N), .AWRU_N(AWRU_N),
    .AWAIT_N(AWAIT_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [25:0] aa; logic [15:0] ado; logic [2:0] strb; logic [2:0] cs; logic [15:0] len;
  } bus_t;
  typedef struct packed { logic [31:0] dv; logic err; logic rd; } res_t;

  bus_t exp_q[$], obs_q[$];
  res_t sb_q[$];
  int   checks = 0, errors = 0;

  // stimulus knobs read by the monitor
  bit          ce_div = 1'b1;
  bit          aw_glitch = 1'b0;
  int          aw_w = 0, aw_n = 0;
  logic [15:0] adi_val = 16'h0;

  // monitor state
  int          tick_cnt = 0, t_busy = 0, t_ack = 0, ack_cnt = 0, viol = 0, len_cur = 0;
  bus_t        mon_cur;
  logic [2:0]  strb_prev = 3'b111, cs_prev = 3'b111;
  logic [25:0] aa_prev = '0;
  logic        busy_prev = 1'b0;

  // Negedge monitor: counts ticks, records bus cycles, then drives CE_R,
  // AWAIT_N and ADI for the next edge.
  always @(negedge CLK) begin
    logic [2:0] strb_now, cs_now;
    logic       aw_want;
    strb_now = {ARD_N, AWRU_N, AWRL_N};
    cs_now   = {ACS2_N, ACS1_N, ACS0_N};
    if (CE_R) begin
      tick_cnt++;
      if (strb_prev != 3'b111) len_cur++;
    end
    if (strb_now != 3'b111 && strb_prev == 3'b111) begin
      mon_cur.aa = AA; mon_cur.ado = ARD_N ? ADO : 16'h0;
      mon_cur.strb = strb_now; mon_cur.cs = cs_now; len_cur = 0;
    end
    if (strb_now == 3'b111 && strb_prev != 3'b111) begin
      mon_cur.len = 16'(len_cur);
      obs_q.push_back(mon_cur);
    end
    if (strb_now != 3'b111 && cs_now == 3'b111) viol++;
    if (cs_now != 3'b111 && cs_now == cs_prev && AA != aa_prev) viol++;
    if (BUSY && !busy_prev) t_busy = tick_cnt;
    if (ACK) begin t_ack = tick_cnt; ack_cnt++; end
    strb_prev = strb_now; cs_prev = cs_now; aa_prev = AA; busy_prev = BUSY;
    CE_R = ce_div ? ~CE_R : 1'b1;
    aw_want = !(aw_n > 0 && strb_now != 3'b111 && len_cur < aw_w + aw_n);
    AWAIT_N = (aw_glitch && !CE_R) ? ~aw_want : aw_want;
    ADI = AWAIT_N ? adi_val : ~adi_val;
  end

  function automatic void exp_cyc(input logic [25:0] aa, input logic [15:0] ado,
                                   input logic [2:0] strb, input logic [2:0] cs, input int len);
    bus_t e;
    e.aa = aa; e.ado = ado; e.strb = strb; e.cs = cs; e.len = 16'(len);
    exp_q.push_back(e);
  endfunction

  // One request through to ACK; compares result, latency and bus cycles.
  task automatic run_req(input string nm, input logic [26:0] a, input logic [31:0] d,
                         input logic [3:0] we, input logic sz, input int lat,
                         input logic [31:0] edo, input logic eerr, input bit hold);
    res_t r;
    bus_t o, e;
    int   n;
    @(negedge CLK); #2;
    ADDR = a; DI = d; WE = we; SIZE = sz; REQ = 1'b1;
    r.dv = edo; r.err = eerr; r.rd = (we == 4'h0);
    sb_q.push_back(r);
    n = 0;
    while (ACK !== 1'b1 && n < 2000) begin @(negedge CLK); #2; n++; end
    checks++;
    if (ACK !== 1'b1) begin
      errors++;
      $display("FAIL %s ack: got none within %0d clocks, want ACK", nm, n);
      REQ = 1'b0; sb_q.delete(); exp_q.delete(); obs_q.delete();
      return;
    end
    if (!hold) REQ = 1'b0;
    r = sb_q.pop_front();
    checks++;
    if (ERR !== r.err) begin errors++; $display("FAIL %s err: got %b want %b", nm, ERR, r.err); end
    if (r.rd) begin
      checks++;
      if (DO !== r.dv) begin errors++; $display("FAIL %s do: got %h want %h", nm, DO, r.dv); end
    end
    checks++;
    if (t_ack - t_busy != lat) begin
      errors++; $display("FAIL %s latency: got %0d ticks want %0d", nm, t_ack - t_busy, lat);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s cycles: got %0d want %0d", nm, obs_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s cycle: got aa=%h ado=%h strb=%b cs=%b len=%0d want aa=%h ado=%h strb=%b cs=%b len=%0d",
                   nm, o.aa, o.ado, o.strb, o.cs, o.len, e.aa, e.ado, e.strb, e.cs, e.len);
        end
      end
    end
    exp_q.delete(); obs_q.delete();
    @(negedge CLK); #2;
    checks++;
    if ({BUSY, ACK, ERR} !== 3'b000) begin
      errors++; $display("FAIL %s after_ack: got busy/ack/err=%b want 000", nm, {BUSY, ACK, ERR});
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    checks++;
    if ({ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N} !== 6'h3F) begin
      errors++; $display("FAIL reset strobes: got %b want 111111", {ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N});
    end
    checks++;
    if (AA !== 26'h0 || ADO !== 16'h0 || DO !== 32'h0) begin
      errors++; $display("FAIL reset data: got aa=%h ado=%h do=%h want zeros", AA, ADO, DO);
    end
    checks++;
    if ({ACK, BUSY, ERR} !== 3'b000) begin
      errors++; $display("FAIL reset flags: got %b want 000", {ACK, BUSY, ERR});
    end
    RST_N = 1'b1;
  endtask

  task automatic test_cs0_read();
    CS0_WAIT = 4'd2; adi_val = 16'h5A5A; aw_n = 0;
    exp_cyc(26'h2000002, 16'h0, 3'b011, 3'b110, 3);
    run_req("cs0_read16", 27'h2000002, 32'h0, 4'h0, 1'b0, 5, 32'h0000_5A5A, 1'b0, 1'b0);
  endtask

  task automatic test_cs1_write32();
    CS1_WAIT = 4'd0;
    // AA carries the low 26 address bits, so 0x4000000 appears as 0
    exp_cyc(26'h0000000, 16'h1234, 3'b100, 3'b101, 1);
    exp_cyc(26'h0000002, 16'h5678, 3'b100, 3'b101, 1);
    run_req("cs1_write32", 27'h4000000, 32'h1234_5678, 4'hF, 1'b1, 6, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_partial_write();
    CS1_WAIT = 4'd0; CS2_WAIT = 4'd1;
    exp_cyc(26'h0000012, 16'hBBBB, 3'b110, 3'b101, 1);
    run_req("write32_we0001", 27'h4000010, 32'hAAAA_BBBB, 4'b0001, 1'b1, 3, 32'h0, 1'b0, 1'b0);
    exp_cyc(26'h0000010, 16'hAAAA, 3'b100, 3'b101, 1);
    run_req("write32_we1100", 27'h4000010, 32'hAAAA_BBBB, 4'b1100, 1'b1, 3, 32'h0, 1'b0, 1'b0);
    exp_cyc(26'h1800006, 16'hCAFE, 3'b101, 3'b011, 2);
    run_req("cs2_write16_hi", 27'h5800006, 32'hFFFF_CAFE, 4'b0010, 1'b0, 4, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_await_stretch();
    CS2_WAIT = 4'd1; adi_val = 16'hBEEF; aw_w = 1; aw_n = 7; aw_glitch = 1'b1;
    exp_cyc(26'h1800010, 16'h0, 3'b011, 3'b011, 1 + 1 + 7);
    run_req("cs2_await7", 27'h5800010, 32'h0, 4'h0, 1'b0, 11, 32'h0000_BEEF, 1'b0, 1'b0);
    aw_n = 0; aw_glitch = 1'b0;
  endtask

  task automatic test_timeout();
    CS0_WAIT = 4'd1; adi_val = 16'h1111; aw_w = 1; aw_n = 1000;
    exp_cyc(26'h2000100, 16'h0, 3'b011, 3'b110, 1 + 8);
    run_req("timeout32", 27'h2000100, 32'h0, 4'h0, 1'b1, 11, 32'hFFFF_0000, 1'b1, 1'b0);
    aw_n = 0;
  endtask

  task automatic test_dummy();
    run_req("dummy_read", 27'h1000000, 32'h0, 4'h0, 1'b1, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_req("dummy_write", 27'h1000000, 32'h9999_9999, 4'hF, 1'b1, 1, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    ce_div = 1'b0; CS1_WAIT = 4'd0; adi_val = 16'h1357;
    exp_cyc(26'h0000020, 16'h0, 3'b011, 3'b101, 1);
    run_req("b2b_first", 27'h4000020, 32'h0, 4'h0, 1'b0, 3, 32'h0000_1357, 1'b0, 1'b1);
    exp_cyc(26'h0000020, 16'h0, 3'b011, 3'b101, 1);
    run_req("b2b_second", 27'h4000020, 32'h0, 4'h0, 1'b0, 3, 32'h0000_1357, 1'b0, 1'b0);
    ce_div = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n, a0;
    CS0_WAIT = 4'd4; adi_val = 16'h2468;
    @(negedge CLK); #2;
    ADDR = 27'h2000004; DI = 32'h0; WE = 4'h0; SIZE = 1'b0; REQ = 1'b1;
    n = 0;
    while (ARD_N !== 1'b0 && n < 200) begin @(negedge CLK); #2; n++; end
    checks++;
    if (ARD_N !== 1'b0) begin errors++; $display("FAIL midreset strobe: got ARD_N=%b want 0", ARD_N); end
    a0 = ack_cnt;
    RST_N = 1'b0; REQ = 1'b0;
    @(negedge CLK); #2;
    checks++;
    if ({ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N, BUSY, ACK} !== 8'b11111100) begin
      errors++; $display("FAIL midreset bus: got %b want 11111100",
                         {ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRL_N, AWRU_N, BUSY, ACK});
    end
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    #2;
    checks++;
    if (ack_cnt != a0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL midreset noack: got acks=%0d busy=%b want %0d 0", ack_cnt - a0, BUSY, 0);
    end
    obs_q.delete(); exp_q.delete(); sb_q.delete();
    exp_cyc(26'h2000004, 16'h0, 3'b011, 3'b110, 5);
    run_req("after_reset", 27'h2000004, 32'h0, 4'h0, 1'b0, 7, 32'h0000_2468, 1'b0, 1'b0);
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0) begin errors++; $display("FAIL bus_rules: got %0d strobe/addr faults want 0", viol); end
  endtask

  initial begin
    REQ = 1'b0; ADDR = '0; DI = '0; WE = '0; SIZE = 1'b0;
    CS0_WAIT = '0; CS1_WAIT = '0; CS2_WAIT = '0;
    test_reset();
    test_cs0_read();
    test_cs1_write32();
    test_partial_write();
    test_await_stretch();
    test_timeout();
    test_dummy();
    test_back_to_back();
    test_reset_mid();
    test_bus_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
